// File: rtl/ppu_vram_arbiter.sv
// Shares the single VRAM read port between the background and sprite fetchers.
// Sprite requests win; a lost response is abandoned after TIMEOUT wait cycles.
module ppu_vram_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int TIMEOUT    = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  sprite_detected_in,
  input  logic                  bg_req_in,
  input  logic [ADDR_WIDTH-1:0] bg_addr_in,
  output logic [7:0]            bg_data_out,
  output logic                  bg_data_valid_out,
  input  logic                  spr_req_in,
  input  logic [ADDR_WIDTH-1:0] spr_addr_in,
  output logic [7:0]            spr_data_out,
  output logic                  spr_data_valid_out,
  output logic                  mem_free_out,
  output logic [ADDR_WIDTH-1:0] vram_addr_out,
  output logic                  vram_rd_out,
  input  logic [7:0]            vram_data_in,
  input  logic                  vram_data_valid_in,
  output logic                  timeout_out
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RETIRE
  } state_t;

  typedef enum logic [1:0] {
    O_NONE,
    O_BG,
    O_SPR
  } owner_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

  state_t                state_q, state_d;
  owner_t                owner_q, owner_d;
  logic [7:0]            wait_cnt_q, wait_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  rd_q, rd_d;
  logic [7:0]            bg_data_q, bg_data_d;
  logic                  bg_vld_q, bg_vld_d;
  logic [7:0]            spr_data_q, spr_data_d;
  logic                  spr_vld_q, spr_vld_d;
  logic                  to_q, to_d;

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    wait_cnt_d = wait_cnt_q;
    addr_d     = addr_q;
    rd_d       = 1'b0;
    bg_data_d  = bg_data_q;
    bg_vld_d   = 1'b0;
    spr_data_d = spr_data_q;
    spr_vld_d  = 1'b0;
    to_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (spr_req_in) begin
          addr_d     = spr_addr_in;
          owner_d    = O_SPR;
          rd_d       = 1'b1;
          wait_cnt_d = 8'd0;
          state_d    = S_WAIT;
        end else if (bg_req_in && !sprite_detected_in) begin
          addr_d     = bg_addr_in;
          owner_d    = O_BG;
          rd_d       = 1'b1;
          wait_cnt_d = 8'd0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        // a response in the final wait cycle still counts
        if (vram_data_valid_in) begin
          if (owner_q == O_SPR) begin
            spr_data_d = vram_data_in;
            spr_vld_d  = 1'b1;
          end else begin
            bg_data_d = vram_data_in;
            bg_vld_d  = 1'b1;
          end
          state_d = S_RETIRE;
        end else if (wait_cnt_q == LAST_WAIT) begin
          to_d    = 1'b1;
          state_d = S_RETIRE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_RETIRE: begin
        owner_d = O_NONE;
        state_d = S_IDLE;
      end
      default: begin
        owner_d = O_NONE;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= S_IDLE;
      owner_q    <= O_NONE;
      wait_cnt_q <= 8'd0;
      addr_q     <= '0;
      rd_q       <= 1'b0;
      bg_data_q  <= 8'd0;
      bg_vld_q   <= 1'b0;
      spr_data_q <= 8'd0;
      spr_vld_q  <= 1'b0;
      to_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q     <= addr_d;
      rd_q       <= rd_d;
      bg_data_q  <= bg_data_d;
      bg_vld_q   <= bg_vld_d;
      spr_data_q <= spr_data_d;
      spr_vld_q  <= spr_vld_d;
      to_q       <= to_d;
    end
  end

  assign mem_free_out       = (state_q == S_IDLE) || (owner_q == O_SPR);
  assign vram_addr_out      = addr_q;
  assign vram_rd_out        = rd_q;
  assign bg_data_out        = bg_data_q;
  assign bg_data_valid_out  = bg_vld_q;
  assign spr_data_out       = spr_data_q;
  assign spr_data_valid_out = spr_vld_q;
  assign timeout_out        = to_q;

endmodule

// File: doc/ppu_vram_arbiter.md
# ppu_vram_arbiter

Single-port VRAM read arbiter for the PPU pixel pipeline. It shares one VRAM read port between the background fetcher and the sprite fetcher. It serialises their requests with sprite-first priority, routes returned bytes to the owning requester, and produces the `mem_free` indication the sprite fetcher consumes. It sits between both fetchers and the VRAM read port, and it recovers from lost responses with a timeout.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: VRAM address width.
- `TIMEOUT`, 8: maximum cycles spent in WAIT before the request is abandoned. Legal range is 2..255.

Ports:
- `clk_in`  in  1  system clock; the only clock.
- `rst_in`  in  1  synchronous, active-high reset.
- `sprite_detected_in`  in  1  sprite hit from the sprite fetcher. While high, new background requests are not granted.
- `bg_req_in`  in  1  background request level. Held high with a stable address until `bg_data_valid_out`.
- `bg_addr_in`  in  ADDR_WIDTH  background read address.
- `bg_data_out`  out  8  byte returned to background.
- `bg_data_valid_out`  out  1  one-cycle strobe qualifying `bg_data_out`.
- `spr_req_in`  in  1  sprite request level, same protocol as background.
- `spr_addr_in`  in  ADDR_WIDTH  sprite read address.
- `spr_data_out`  out  8  byte returned to sprite.
- `spr_data_valid_out`  out  1  one-cycle strobe qualifying `spr_data_out`.
- `mem_free_out`  out  1  high when background does not own the port (state IDLE, or owner = SPR).
- `vram_addr_out`  out  ADDR_WIDTH  address to VRAM.
- `vram_rd_out`  out  1  one-cycle read strobe.
- `vram_data_in`  in  8  VRAM read data.
- `vram_data_valid_in`  in  1  qualifies `vram_data_in`.
- `timeout_out`  out  1  one-cycle strobe when a request is abandoned.

## Operation
- Registers: `state` ∈ {IDLE, WAIT, RETIRE}; `owner` ∈ {NONE, BG, SPR}; 8-bit `wait_cnt`.
- **IDLE:**
  - If `spr_req_in`: latch `spr_addr_in` into `vram_addr_out`, set owner = SPR, pulse `vram_rd_out`, clear `wait_cnt`, go to WAIT.
  - Else if `bg_req_in && !sprite_detected_in`: same sequence with owner = BG.
  - Otherwise stay in IDLE.
  - `vram_data_valid_in` in IDLE is a stale response and is ignored.
- **WAIT:**
  - On `vram_data_valid_in`: register `vram_data_in` into the owner's data output, assert the owner's valid strobe next cycle, go to RETIRE.
  - Else if `wait_cnt == TIMEOUT-1`: pulse `timeout_out` next cycle, go to RETIRE with no data strobe.
  - Else increment `wait_cnt`.
  - If valid and timeout coincide, valid wins and there is no `timeout_out`.
- **RETIRE:**
  - Lasts one cycle. Valid strobe or `timeout_out` is high during it.
  - Owner → NONE, go to IDLE.
  - The cycle exists so a requester can drop its `req` before IDLE samples again.
- A requester that times out keeps `req` high; the arbiter reissues the request on the next IDLE cycle.
- `vram_addr_out` holds its value from issue until the next issue; it is not cleared in IDLE.
- The data output of the non-owner never changes.
- A `sprite_detected_in` assertion during a background WAIT does not abort it; the background transfer completes first.

## Timing
- **Reset values:** all outputs 0, `vram_addr_out` = 0, `mem_free_out` = 1, state IDLE, owner NONE, `wait_cnt` = 0.
- **Issue latency:** request sampled in IDLE at cycle 0 → `vram_rd_out` high in cycle 1 only. `vram_addr_out` is valid from cycle 1.
- **Return latency:** `vram_data_valid_in` at cycle k in WAIT → owner strobe and data at cycle k+1 (RETIRE) → IDLE at k+2.
  - Minimum spacing between `vram_rd_out` strobes is 3 cycles, with response at k = 1.
- **Timeout:** with no response, `timeout_out` is high in cycle TIMEOUT+1 counted from the issue sample. IDLE follows in the next cycle.
- **`mem_free_out`:** combinational from registered state and owner. It goes low in the cycle after a BG grant and high again in IDLE.
- **Reset mid-WAIT:** the transaction is abandoned with no strobes. A late `vram_data_valid_in` after reset is ignored.

## Test plan
- Single BG request, addr 0x9800, VRAM returns 0x5A at k=2 → `vram_rd_out` at cycle 1 with addr 0x9800; `bg_data_out` = 0x5A with strobe at cycle 3; `spr_data_valid_out` stays 0; `mem_free_out` low during cycles 1–3.
- BG and SPR requests in the same IDLE cycle (SPR 0x8010, BG 0x9801) → SPR issued first; BG issued in the IDLE cycle after SPR RETIRE; each byte is routed only to its owner.
- BG request with `sprite_detected_in` high → no issue while detect is high; issue occurs the cycle after detect falls.
- Withheld response with `TIMEOUT` = 8 → `timeout_out` strobes once at cycle 9, then the request is reissued. A response on reissue is delivered normally.
- Response and timeout in the same cycle → data strobe only, no `timeout_out`.
- Reset asserted in WAIT, then stale `vram_data_valid_in` → no strobes; all outputs at reset values; `mem_free_out` = 1.
